systolic_result_drain: RTL and testbench
========================================

Name: systolic_result_drain

Overview:
- Sits at the output end of the systolic array top.
- Captures one column of per-row partial sums (NUM_PE_ROWS values) when the array flags them valid.
- Requantizes each value with a rounding right shift and signed saturation.
- Streams the values out one row per beat over a valid/ready interface to the writeback buffer.

Parameters:
PARTIAL_SUM_BW, 19, width of each signed partial sum from a PE row
NUM_PE_ROWS, 8, number of results captured per column (>=2)
OUT_BW, 8, width of each signed requantized output
SHAMT_BW, 5, width of the shift-amount input
IDX_BW, $clog2(NUM_PE_ROWS), width of the row index

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
cap_valid  in  1  array results on result_flat are valid this cycle
cap_ready  out  1  drain can accept a capture (high only in IDLE)
result_flat  in  NUM_PE_ROWS*PARTIAL_SUM_BW  row r at bits [r*PARTIAL_SUM_BW +: PARTIAL_SUM_BW], signed
shamt  in  SHAMT_BW  right-shift amount, sampled with the capture
out_valid  out  1  out_data holds a valid beat
out_ready  in  1  downstream accepts the beat
out_data  out  OUT_BW  requantized signed value for row out_idx
out_idx  out  IDX_BW  row index of current beat
out_last  out  1  current beat is row NUM_PE_ROWS-1
busy  out  1  state is DRAIN
overrun  out  1  sticky: a capture was offered while cap_ready=0

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, idx=0, overrun=0.
  - Row buffer cleared to 0; latched shamt=0.
  - Outputs: cap_ready=1, out_valid=0, out_last=0, busy=0, out_data=0, out_idx=0.
  - Reset mid-DRAIN abandons the column; no further beats.
- FSM: IDLE, DRAIN.
  - IDLE, cap_valid=1: latch all rows and shamt, idx<=0, go to DRAIN.
  - DRAIN, out_valid&&out_ready with idx<NUM_PE_ROWS-1: idx<=idx+1.
  - DRAIN, out_valid&&out_ready with idx==NUM_PE_ROWS-1: idx<=0, go to IDLE.
  - DRAIN, out_ready=0: hold idx; out_data/out_idx stable (no beat drop, no change while stalled).
- Handshake and latency:
  - cap_ready = (state==IDLE), registered-state decode only.
  - out_valid = (state==DRAIN).
  - Capture accepted at edge t → row 0 presented (out_valid=1) during cycle t+1.
  - Back-to-back with out_ready=1: NUM_PE_ROWS beats in consecutive cycles.
  - cap_ready returns 1 the cycle after the last beat's handshake.
  - Minimum column period is NUM_PE_ROWS+1 cycles.
- Overrun:
  - cap_valid=1 while cap_ready=0 sets overrun. Data is ignored; the buffer is untouched.
  - overrun is cleared only by rst.
  - cap_valid=1 on the same edge as the last handshake is also an overrun (cap_ready=0 that cycle).
- Requantization, combinational from buffer[idx] and latched shamt:
  - Sign-extend the value to PARTIAL_SUM_BW+1 bits (x).
  - If shamt==0: y=x. Else: y=(x + (1<<(shamt-1))) >>> shamt (arithmetic shift, round half toward +inf).
  - shamt>=PARTIAL_SUM_BW: y is 0 or -1 per sign after rounding; no X.
  - Saturate y to [-(2^(OUT_BW-1)), 2^(OUT_BW-1)-1].
  - The extra bit guarantees no wrap when rounding the maximum positive input.
- out_last = out_valid && (idx==NUM_PE_ROWS-1).

Test Plan:
- Reset, then capture rows r=0..7 of value 10*r with shamt=0 and out_ready=1 → out_valid from the next cycle, out_data=0,10,...,70 in 8 consecutive cycles, out_idx 0..7, out_last only on beat 7, cap_ready=1 on the following cycle.
- Rounding with shamt=2: row0=300 → 75; row1=-300 → -75; row2=6 → 2; row3=-6 → -1; row4=1 → 0.
- Saturation with shamt=0: row0=1000 → 127; row1=-1000 → -128. With shamt=4: row2=262143 → 127, no wrap; row3=-262144 → -128.
- Backpressure: hold out_ready=0 for 3 cycles at idx=2, then toggle 1/0 → out_data/out_idx stable while stalled, every row delivered exactly once, in order.
- Overrun: pulse cap_valid during DRAIN with different data → overrun=1 and stays 1, drained values are from the original column. Next capture in IDLE works normally; overrun stays 1 until rst.
- Assert rst at beat 4 of a drain → next cycle out_valid=0, cap_ready=1, overrun=0, out_idx=0. A fresh capture then drains rows from 0.

Source files
------------

// File: rtl/systolic_result_drain_if.sv
// Capture and drain-stream bundle between the systolic array, the result drain
// and the writeback buffer. The drain is the master of the output stream.
interface systolic_result_drain_if #(
  parameter int PARTIAL_SUM_BW = 19,
  parameter int NUM_PE_ROWS    = 8,
  parameter int OUT_BW         = 8,
  parameter int SHAMT_BW       = 5,
  parameter int IDX_BW         = $clog2(NUM_PE_ROWS)
) ();
  logic                                  cap_valid;
  logic                                  cap_ready;
  logic [NUM_PE_ROWS*PARTIAL_SUM_BW-1:0] result_flat;
  logic [SHAMT_BW-1:0]                   shamt;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [OUT_BW-1:0]                     out_data;
  logic [IDX_BW-1:0]                     out_idx;
  logic                                  out_last;

  modport master (
    input  cap_valid, result_flat, shamt, out_ready,
    output cap_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    output cap_valid, result_flat, shamt, out_ready,
    input  cap_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Captures a column of partial sums from the systolic array, requantizes each
// row with a rounding right shift plus saturation, and streams one row per beat.
module systolic_result_drain #(
  parameter int PARTIAL_SUM_BW = 19,
  parameter int NUM_PE_ROWS    = 8,
  parameter int OUT_BW         = 8,
  parameter int SHAMT_BW       = 5,
  parameter int IDX_BW         = $clog2(NUM_PE_ROWS)
) (
  input  logic clk,
  input  logic rst,
  systolic_result_drain_if.master bus,
  output logic busy,
  output logic overrun
);
  localparam int EXT_BW    = PARTIAL_SUM_BW + 1;
  localparam int SH_EFF_BW = $clog2(PARTIAL_SUM_BW + 1);
  localparam logic [IDX_BW-1:0]        LAST_IDX = IDX_BW'(NUM_PE_ROWS - 1);
  localparam logic signed [EXT_BW-1:0] SAT_MAX  = EXT_BW'((2 ** (OUT_BW - 1)) - 1);
  localparam logic signed [EXT_BW-1:0] SAT_MIN  = EXT_BW'(-(2 ** (OUT_BW - 1)));

  typedef enum logic [0:0] {IDLE, DRAIN} state_t;

  state_t                     state_reg, state_next;
  logic [IDX_BW-1:0]          idx_reg, idx_next;
  logic [SHAMT_BW-1:0]        shamt_reg;
  logic                       overrun_reg;
  logic [PARTIAL_SUM_BW-1:0]  rows_reg [NUM_PE_ROWS];
  logic [PARTIAL_SUM_BW-1:0]  cap_rows [NUM_PE_ROWS];

  logic                       capture_fire;
  logic                       beat_fire;

  generate
    for (genvar gi = 0; gi < NUM_PE_ROWS; gi++) begin : g_slice
      assign cap_rows[gi] = bus.result_flat[gi*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
    end
  endgenerate

  assign capture_fire = (state_reg == IDLE) && bus.cap_valid;
  assign beat_fire    = (state_reg == DRAIN) && bus.out_ready;

  // Next-state and index logic
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.cap_valid) begin
          state_next = DRAIN;
          idx_next   = '0;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + IDX_BW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Column buffer is written only on an accepted capture; offers during DRAIN are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      shamt_reg <= '0;
      for (int r = 0; r < NUM_PE_ROWS; r++) begin
        rows_reg[r] <= '0;
      end
    end else if (capture_fire) begin
      shamt_reg <= bus.shamt;
      for (int r = 0; r < NUM_PE_ROWS; r++) begin
        rows_reg[r] <= cap_rows[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_reg <= 1'b0;
    end else if (bus.cap_valid && (state_reg != IDLE)) begin
      overrun_reg <= 1'b1;
    end
  end

  // Requantization of the row currently addressed by idx_reg
  logic signed [EXT_BW-1:0]    x_ext;
  logic        [SH_EFF_BW-1:0] sh_eff;
  logic        [EXT_BW-1:0]    round_val;
  logic signed [EXT_BW-1:0]    sum_val;
  logic signed [EXT_BW-1:0]    y_val;
  logic        [OUT_BW-1:0]    sat_val;

  always_comb begin
    x_ext = {rows_reg[idx_reg][PARTIAL_SUM_BW-1], rows_reg[idx_reg]};
    // Shifts at or beyond the input width all round to 0, so clamp to keep the
    // rounding constant inside the extended word.
    if (32'(shamt_reg) >= PARTIAL_SUM_BW) begin
      sh_eff = SH_EFF_BW'(PARTIAL_SUM_BW);
    end else begin
      sh_eff = SH_EFF_BW'(shamt_reg);
    end
    round_val = '0;
    sum_val   = x_ext;
    y_val     = x_ext;
    if (sh_eff != '0) begin
      round_val = EXT_BW'(1) << (sh_eff - SH_EFF_BW'(1));
      sum_val   = x_ext + $signed(round_val);
      y_val     = sum_val >>> sh_eff;
    end
    if (y_val > SAT_MAX) begin
      sat_val = SAT_MAX[OUT_BW-1:0];
    end else if (y_val < SAT_MIN) begin
      sat_val = SAT_MIN[OUT_BW-1:0];
    end else begin
      sat_val = y_val[OUT_BW-1:0];
    end
  end

  assign bus.cap_ready = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DRAIN);
  assign bus.out_data  = sat_val;
  assign bus.out_idx   = idx_reg;
  assign bus.out_last  = (state_reg == DRAIN) && (idx_reg == LAST_IDX);
  assign busy          = (state_reg == DRAIN);
  assign overrun       = overrun_reg;

  logic unused_beat;
  assign unused_beat = beat_fire;
endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain: vector table, directed corner
// sequences and randomized columns against an arithmetic reference model.
module tb_systolic_result_drain;
  localparam int PSB = 19;
  localparam int NR  = 8;
  localparam int OBW = 8;
  localparam int SBW = 5;
  localparam int IBW = 3;

  typedef int row_arr_t [NR];
  typedef struct {
    int value;
    int sh;
    int exp_out;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic overrun;
  int   checks = 0;
  int   errors = 0;

  systolic_result_drain_if #(
    .PARTIAL_SUM_BW(PSB), .NUM_PE_ROWS(NR), .OUT_BW(OBW), .SHAMT_BW(SBW), .IDX_BW(IBW)
  ) bus ();

  systolic_result_drain #(
    .PARTIAL_SUM_BW(PSB), .NUM_PE_ROWS(NR), .OUT_BW(OBW), .SHAMT_BW(SBW), .IDX_BW(IBW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Exact math on 64-bit integers: round half up, then clamp to the output range.
  function automatic longint model(input longint v, input int sh);
    longint y;
    longint lim;
    lim = longint'(1) << (OBW - 1);
    if (sh == 0) y = v;
    else y = (v + (longint'(1) << (sh - 1))) >>> sh;
    if (y > lim - 1) y = lim - 1;
    if (y < -lim) y = -lim;
    return y;
  endfunction

  task automatic drive_rows(input row_arr_t rows);
    for (int i = 0; i < NR; i++) begin
      bus.result_flat[i*PSB +: PSB] = PSB'(rows[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cap_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.shamt = '0;
    bus.result_flat = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 3 cycles at idx 2 then toggle
  task automatic run_column(input row_arr_t rows, input int sh, input int mode,
                            input int pulse_at, input bit use_fixed, input int fixed_exp);
    int exp_idx;
    int cyc;
    int stalls;
    bit tog;
    bit rdy;
    bit was_stall;
    bit pulsed;
    longint pd;
    longint pi;
    longint exp_d;
    row_arr_t alt;
    @(negedge clk);
    check("cap_ready_idle", bus.cap_ready, 1);
    drive_rows(rows);
    bus.shamt = SBW'(sh);
    bus.cap_valid = 1'b1;
    @(negedge clk);
    bus.cap_valid = 1'b0;
    check("first_beat_valid", bus.out_valid, 1);
    check("first_beat_idx", bus.out_idx, 0);
    exp_idx = 0; cyc = 0; stalls = 0; tog = 1'b1; was_stall = 1'b0; pulsed = 1'b0;
    pd = 0; pi = 0;
    while (exp_idx < NR && cyc < 400) begin
      check("drain_valid", bus.out_valid, 1);
      if (was_stall) begin
        check("stall_data_hold", $signed(bus.out_data), pd);
        check("stall_idx_hold", bus.out_idx, pi);
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: begin
          if (exp_idx < 2) rdy = 1'b1;
          else if (exp_idx == 2 && stalls < 3) begin rdy = 1'b0; stalls++; end
          else begin rdy = tog; tog = ~tog; end
        end
      endcase
      bus.out_ready = rdy;
      if (exp_idx == pulse_at && !pulsed) begin
        for (int i = 0; i < NR; i++) alt[i] = (rows[i] + 12345) % 200000;
        drive_rows(alt);
        bus.shamt = SBW'(sh + 1);
        bus.cap_valid = 1'b1;
        pulsed = 1'b1;
      end
      if (rdy) begin
        exp_d = use_fixed ? longint'(fixed_exp) : model(rows[exp_idx], sh);
        check("beat_idx", bus.out_idx, exp_idx);
        check("beat_data", $signed(bus.out_data), exp_d);
        check("beat_last", bus.out_last, (exp_idx == NR - 1) ? 1 : 0);
        exp_idx++;
        was_stall = 1'b0;
      end else begin
        was_stall = 1'b1;
        pd = $signed(bus.out_data);
        pi = bus.out_idx;
      end
      @(negedge clk);
      bus.cap_valid = 1'b0;
      cyc++;
    end
    if (cyc >= 400) check("drain_timeout", cyc, 0);
    check("after_valid", bus.out_valid, 0);
    check("after_cap_ready", bus.cap_ready, 1);
    check("after_busy", busy, 0);
    bus.out_ready = 1'b0;
    $display("column sh=%0d mode=%0d pulse=%0d beats=%0d cycles=%0d", sh, mode, pulse_at, exp_idx, cyc);
  endtask

  vec_t     vecs [16];
  row_arr_t rows;

  initial begin
    vecs[0]  = '{300, 2, 75};        vecs[1]  = '{-300, 2, -75};
    vecs[2]  = '{6, 2, 2};           vecs[3]  = '{-6, 2, -1};
    vecs[4]  = '{1, 2, 0};           vecs[5]  = '{1000, 0, 127};
    vecs[6]  = '{-1000, 0, -128};    vecs[7]  = '{262143, 4, 127};
    vecs[8]  = '{-262144, 4, -128};  vecs[9]  = '{5, 31, 0};
    vecs[10] = '{-262144, 31, 0};    vecs[11] = '{262143, 19, 0};
    vecs[12] = '{-1, 1, 0};          vecs[13] = '{-3, 1, -1};
    vecs[14] = '{255, 1, 127};       vecs[15] = '{-258, 1, -128};

    do_reset();
    check("rst_cap_ready", bus.cap_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", $signed(bus.out_data), 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_overrun", overrun, 0);
    $display("reset checked");

    for (int i = 0; i < NR; i++) rows[i] = 10 * i;
    run_column(rows, 0, 0, -1, 1'b0, 0);

    rows = '{300, -300, 6, -6, 1, 0, -2, 2};
    run_column(rows, 2, 0, -1, 1'b0, 0);
    rows = '{1000, -1000, 127, -128, 128, -129, 0, -1};
    run_column(rows, 0, 0, -1, 1'b0, 0);
    rows = '{0, 0, 262143, -262144, 2040, 2047, -2056, -2057};
    run_column(rows, 4, 0, -1, 1'b0, 0);

    for (int v = 0; v < 16; v++) begin
      for (int i = 0; i < NR; i++) rows[i] = vecs[v].value;
      run_column(rows, vecs[v].sh, 0, -1, 1'b1, vecs[v].exp_out);
    end

    for (int i = 0; i < NR; i++) rows[i] = 1000 * i - 3500;
    run_column(rows, 3, 2, -1, 1'b0, 0);

    check("overrun_before", overrun, 0);
    for (int i = 0; i < NR; i++) rows[i] = 7 * i + 1;
    run_column(rows, 0, 1, 3, 1'b0, 0);
    check("overrun_set", overrun, 1);
    for (int i = 0; i < NR; i++) rows[i] = -20 * i;
    run_column(rows, 1, 0, -1, 1'b0, 0);
    check("overrun_sticky", overrun, 1);

    // Reset while beat 4 is on the bus
    for (int i = 0; i < NR; i++) rows[i] = 50 + i;
    @(negedge clk);
    drive_rows(rows);
    bus.shamt = '0;
    bus.cap_valid = 1'b1;
    @(negedge clk);
    bus.cap_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      check("pre_rst_idx", bus.out_idx, b);
      @(negedge clk);
    end
    check("rst_mid_idx4", bus.out_idx, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_cap_ready", bus.cap_ready, 1);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_out_idx", bus.out_idx, 0);
    $display("reset mid-drain checked");
    for (int i = 0; i < NR; i++) rows[i] = 90 - i;
    run_column(rows, 0, 0, -1, 1'b0, 0);
    check("overrun_clear_after_rst", overrun, 0);

    // Capture offered on the same edge as the final handshake
    for (int i = 0; i < NR; i++) rows[i] = 3 * i;
    run_column(rows, 0, 0, NR - 1, 1'b0, 0);
    check("overrun_last_edge", overrun, 1);

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NR; i++) rows[i] = int'($urandom_range(0, (1 << PSB) - 1)) - (1 << (PSB - 1));
      run_column(rows, int'($urandom_range(0, 31)), 1, -1, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
